// File: rtl/call_stack_pkg.sv
// Shared constants and types for the hardware call/return stack.
package call_stack_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_PTR_W = $clog2(DEF_DEPTH);

  // Operation decoded from {push, pop}; the encoding matches that bit pair.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_TAIL = 2'b11
  } op_e;

endpackage

// File: rtl/call_stack_ram.sv
// Return-address storage: one synchronous write port, one asynchronous read
// port, no reset (contents above the live count are never exposed).
module stack_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// Hardware call/return stack: saves pc_in+1 on a call, hands the top entry
// back to the PC on a return, with sticky overflow/underflow flags.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data,
  output logic             PCincr,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;   // count spans 0..DEPTH inclusive

  logic [CW-1:0]    count, cnt_nxt;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    waddr;
  logic             we;
  logic             ovf_set, udf_set;
  logic [WIDTH-1:0] rdata;
  op_e              op;

  // Return address is the instruction after the call, wrapping modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] ret_addr(input logic [WIDTH-1:0] pc);
    return pc + WIDTH'(1);
  endfunction

  assign op      = op_e'({push, pop});
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // At count == DEPTH the low bits are 0, so subtracting 1 wraps to DEPTH-1.
  assign top_idx = count[AW-1:0] - AW'(1);

  // Decode the requested operation into a RAM write, next count and error sets.
  always_comb begin
    we      = 1'b0;
    waddr   = count[AW-1:0];
    cnt_nxt = count;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    unique case (op)
      OP_PUSH: begin
        if (!full) begin
          we      = 1'b1;
          cnt_nxt = count + CW'(1);
        end else begin
          ovf_set = 1'b1;
        end
      end
      OP_POP: begin
        if (!empty) cnt_nxt = count - CW'(1);
        else        udf_set = 1'b1;
      end
      OP_TAIL: begin
        we = 1'b1;
        if (!empty) begin
          waddr = top_idx;        // tail call overwrites the top in place
        end else begin
          cnt_nxt = count + CW'(1);
          udf_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Count and sticky flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= cnt_nxt;
      overflow  <= (overflow  & ~clr_err) | ovf_set;
      underflow <= (underflow & ~clr_err) | udf_set;
    end
  end

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we & rst_n),
    .waddr (waddr),
    .wdata (ret_addr(pc_in)),
    .raddr (top_idx),
    .rdata (rdata)
  );

  assign data   = empty ? '0 : rdata;
  assign PCincr = ~(pop & ~empty);

endmodule

// File: tb/tb_call_stack.sv
// Directed self-checking bench for call_stack (WIDTH=8, DEPTH=8).
module tb_call_stack;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       push, pop, clr_err;
  logic [7:0] pc_in;
  logic [7:0] data;
  logic       PCincr, empty, full, overflow, underflow;

  int checks = 0;
  int errors = 0;

  call_stack #(.WIDTH(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .pc_in     (pc_in),
    .clr_err   (clr_err),
    .data      (data),
    .PCincr    (PCincr),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic q, input logic [7:0] pc, input logic c);
    push = p; pop = q; pc_in = pc; clr_err = c;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 0);
    tick();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_data", data, 0);
    chk("rst_pcincr", PCincr, 1);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_empty", empty, 1);

    // Call then return
    drive(1, 0, 8'h10, 0); tick();
    chk("s1_data", data, 8'h11);
    chk("s1_empty", empty, 0);
    drive(0, 1, 8'h00, 0); #1;
    chk("s1_pop_pcincr", PCincr, 0);
    chk("s1_pop_data", data, 8'h11);
    tick(); drive(0, 0, 8'h00, 0); #1;
    chk("s1_after_empty", empty, 1);
    chk("s1_after_data", data, 0);
    chk("s1_after_pcincr", PCincr, 1);

    // Fill, overflow, drain
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 8'(i), 0); tick();
    end
    chk("s2_full", full, 1);
    chk("s2_data_top", data, 8'h08);
    chk("s2_ovf_before", overflow, 0);
    drive(1, 0, 8'h50, 0); tick();
    chk("s2_ovf", overflow, 1);
    chk("s2_top_kept", data, 8'h08);
    drive(0, 0, 8'h00, 0); tick();
    chk("s2_ovf_sticky", overflow, 1);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 8'h00, 0); #1;
      chk($sformatf("s2_pop%0d_data", i), data, 8'(8 - i));
      chk($sformatf("s2_pop%0d_pcincr", i), PCincr, 0);
      if (i == 0) chk("s2_full_before_pop", full, 1);
      tick();
      if (i == 0) chk("s2_notfull_after_pop", full, 0);
    end
    drive(0, 0, 8'h00, 0); #1;
    chk("s2_empty", empty, 1);
    drive(0, 0, 8'h00, 1); tick();
    chk("s2_ovf_clr", overflow, 0);

    // Underflow, clear, set-wins
    drive(0, 1, 8'h00, 0); #1;
    chk("s3_pcincr", PCincr, 1);
    chk("s3_data", data, 0);
    tick();
    chk("s3_udf", underflow, 1);
    chk("s3_still_empty", empty, 1);
    drive(0, 0, 8'h00, 1); tick();
    chk("s3_udf_clr", underflow, 0);
    drive(0, 1, 8'h00, 1); tick();
    chk("s3_set_wins", underflow, 1);
    drive(0, 0, 8'h00, 1); tick();
    chk("s3_udf_clr2", underflow, 0);

    // Wrap-around
    drive(1, 0, 8'hFF, 0); tick();
    chk("s4_wrap_data", data, 8'h00);
    chk("s4_wrap_empty", empty, 0);
    drive(0, 1, 8'h00, 0); tick();
    chk("s4_drained", empty, 1);

    // Tail call
    drive(1, 0, 8'h20, 0); tick();
    chk("s5_top", data, 8'h21);
    drive(1, 1, 8'h40, 0); #1;
    chk("s5_tail_pcincr", PCincr, 0);
    chk("s5_tail_data", data, 8'h21);
    tick();
    chk("s5_new_top", data, 8'h41);
    chk("s5_udf_none", underflow, 0);
    drive(0, 1, 8'h00, 0); tick();
    chk("s5_count_one", empty, 1);

    // Tail call while empty behaves as a push and flags underflow
    drive(1, 1, 8'h30, 0); #1;
    chk("s5e_pcincr", PCincr, 1);
    tick();
    chk("s5e_data", data, 8'h31);
    chk("s5e_udf", underflow, 1);
    drive(0, 1, 8'h00, 1); tick();
    chk("s5e_drained", empty, 1);
    chk("s5e_udf_clr", underflow, 0);

    // Asynchronous reset mid-period with 3 entries and flags set
    drive(0, 1, 8'h00, 0); tick();           // underflow set
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 8'(8'h60 + i), 0); tick();
    end
    chk("s6_pre_data", data, 8'h63);
    chk("s6_pre_udf", underflow, 1);
    drive(1, 0, 8'h70, 0);                   // pending push, discarded by reset
    #3 rst_n = 1'b0;
    #1;
    chk("s6_async_empty", empty, 1);
    chk("s6_async_udf", underflow, 0);
    chk("s6_async_ovf", overflow, 0);
    chk("s6_async_data", data, 0);
    chk("s6_async_pcincr", PCincr, 1);
    tick();                                  // edge with reset held and push high
    chk("s6_held_empty", empty, 1);
    rst_n = 1'b1;
    drive(0, 0, 8'h00, 0);
    tick();
    chk("s6_release_empty", empty, 1);
    chk("s6_release_full", full, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
